// File: rtl/usb_rx_line_decoder_pkg.sv
// Shared definitions for the USB full-speed receive line decoder:
// line-state encodings, FSM states and default parameters.
package usb_rx_line_decoder_pkg;

   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_K   = 2'b01,
      LS_J   = 2'b10,
      LS_SE1 = 2'b11
   } line_state_e;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP,
      ERRWAIT
   } rx_state_e;

   localparam int STUFF_LIMIT_DEF = 6;
   localparam int SYNC_MIN_Z_DEF  = 5;

   function automatic logic is_jk(input line_state_e ls);
      return (ls == LS_J) || (ls == LS_K);
   endfunction

endpackage

// File: rtl/usb_rx_line_decoder_if.sv
// Receive-side byte bus from the line decoder to the packet decoder.
interface usb_rx_line_decoder_if;
   logic       rx_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_eop;
   logic       rx_error;

   modport master (output rx_active, rx_valid, rx_data, rx_eop, rx_error);
   modport slave  (input  rx_active, rx_valid, rx_data, rx_eop, rx_error);
endinterface

// File: rtl/usb_rx_line_decoder_unstuff.sv
// NRZI decode and bit-unstuffing: turns J/K samples into decoded bits,
// drops the stuffed 0 after a run of ones and flags a missing stuff bit.
module usb_rx_line_decoder_unstuff
   import usb_rx_line_decoder_pkg::*;
#(
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_strobe,
   input  line_state_e i_ls,
   input  logic        i_en,
   input  logic        i_clr,
   output logic        o_dec,
   output logic        o_bit_valid,
   output logic        o_bit_val,
   output logic        o_stuff_err
);

   localparam int OW = $clog2(STUFF_LIMIT + 1);

   line_state_e   r_prev;
   logic [OW-1:0] r_ones;
   logic          w_jk;
   logic          w_stuff;
   logic          w_take;

   assign w_jk    = is_jk(i_ls);
   assign w_stuff = (r_ones == OW'(STUFF_LIMIT));
   assign w_take  = i_strobe && i_en && w_jk;

   // Decoded value is only meaningful on J/K samples.
   assign o_dec       = (i_ls == r_prev);
   assign o_bit_val   = o_dec;
   assign o_bit_valid = w_take && !w_stuff;
   assign o_stuff_err = w_take && w_stuff && o_dec;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prev <= LS_J;
         r_ones <= '0;
      end else begin
         if (i_strobe && w_jk)
            r_prev <= i_ls;
         if (i_clr)
            r_ones <= '0;
         else if (w_take)
            r_ones <= (o_dec && !w_stuff) ? r_ones + OW'(1) : '0;
      end
   end

endmodule

// File: rtl/usb_rx_line_decoder.sv
// USB FS receive front end: SYNC hunt, byte assembly, EOP and line-error
// detection on top of the NRZI/unstuff stage.
module usb_rx_line_decoder
   import usb_rx_line_decoder_pkg::*;
#(
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF,
   parameter int SYNC_MIN_Z  = SYNC_MIN_Z_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_bit_strobe,
   input  logic                   i_line_dp,
   input  logic                   i_line_dn,
   usb_rx_line_decoder_if.master  o_rx
);

   localparam int ZW = $clog2(SYNC_MIN_Z + 1);

   rx_state_e   r_state, w_next;
   line_state_e w_ls;
   logic [ZW-1:0] r_zcnt;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_sr;
   logic        r_se0_seen;
   logic        r_active, r_valid, r_eop, r_error;
   logic [7:0]  r_data;
   logic        w_clr, w_eop, w_err, w_en;
   logic        w_dec, w_bit_valid, w_bit_val, w_stuff_err;

   assign w_ls = line_state_e'({i_line_dp, i_line_dn});
   assign w_en = (r_state == DATA);

   usb_rx_line_decoder_unstuff #(.STUFF_LIMIT(STUFF_LIMIT)) u_unstuff (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_strobe    (i_bit_strobe),
      .i_ls        (w_ls),
      .i_en        (w_en),
      .i_clr       (w_clr),
      .o_dec       (w_dec),
      .o_bit_valid (w_bit_valid),
      .o_bit_val   (w_bit_val),
      .o_stuff_err (w_stuff_err)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      w_eop  = 1'b0;
      w_err  = 1'b0;
      if (i_bit_strobe) begin
         unique case (r_state)
            IDLE: if (w_ls == LS_K) w_next = SYNC;
            SYNC: begin
               if (!is_jk(w_ls)) begin
                  w_next = IDLE;
               end else if (w_dec) begin
                  if (r_zcnt >= ZW'(SYNC_MIN_Z)) begin
                     w_next = DATA;
                     w_clr  = 1'b1;
                  end else begin
                     w_next = IDLE;
                  end
               end
            end
            DATA: begin
               if (w_ls == LS_SE0) begin
                  w_next = EOP;
               end else if (w_ls == LS_SE1 || w_stuff_err) begin
                  w_err  = 1'b1;
                  w_next = ERRWAIT;
               end
            end
            // A partial byte at SE0 is reported with the EOP itself.
            EOP: begin
               if (w_ls == LS_J) begin
                  w_eop  = 1'b1;
                  w_err  = (r_bitcnt != 3'd0);
                  w_next = IDLE;
               end else if (w_ls != LS_SE0) begin
                  w_err  = 1'b1;
                  w_next = ERRWAIT;
               end
            end
            ERRWAIT: begin
               if (w_ls == LS_J && r_se0_seen) begin
                  w_eop  = 1'b1;
                  w_next = IDLE;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_zcnt     <= '0;
         r_bitcnt   <= '0;
         r_sr       <= '0;
         r_se0_seen <= 1'b0;
         r_active   <= 1'b0;
         r_valid    <= 1'b0;
         r_eop      <= 1'b0;
         r_error    <= 1'b0;
         r_data     <= '0;
      end else begin
         r_valid  <= 1'b0;
         r_eop    <= w_eop;
         r_error  <= w_err;
         r_active <= (w_next == DATA) || (w_next == EOP) || (w_next == ERRWAIT);
         if (i_bit_strobe) begin
            r_se0_seen <= (r_state == ERRWAIT) && (w_ls == LS_SE0);
            if (r_state == IDLE)
               r_zcnt <= ZW'(1);
            else if (r_state == SYNC && is_jk(w_ls) && !w_dec && r_zcnt != ZW'(SYNC_MIN_Z))
               r_zcnt <= r_zcnt + ZW'(1);
         end
         // LSB arrives first, so new bits enter at the top and shift down.
         if (w_clr) begin
            r_bitcnt <= '0;
         end else if (w_bit_valid) begin
            r_sr     <= {w_bit_val, r_sr[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
               r_data  <= {w_bit_val, r_sr[7:1]};
               r_valid <= 1'b1;
            end
         end
      end
   end

   assign o_rx.rx_active = r_active;
   assign o_rx.rx_valid  = r_valid;
   assign o_rx.rx_data   = r_data;
   assign o_rx.rx_eop    = r_eop;
   assign o_rx.rx_error  = r_error;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Directed bench: NRZI/stuffing encoder drives the line, a scoreboard of
// expected strobes (flags, data, cycle) is checked every clock.
module tb_usb_rx_line_decoder;
   import usb_rx_line_decoder_pkg::*;

   logic clk = 1'b0, rst_n = 1'b0, strobe = 1'b0, dp = 1'b1, dn = 1'b0;

   usb_rx_line_decoder_if rx_if ();

   usb_rx_line_decoder dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_bit_strobe (strobe),
      .i_line_dp    (dp),
      .i_line_dn    (dn),
      .o_rx         (rx_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] flags;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   localparam logic [2:0] EV_NONE  = 3'b000;
   localparam logic [2:0] EV_VALID = 3'b100;
   localparam logic [2:0] EV_EOP   = 3'b010;
   localparam logic [2:0] EV_ERR   = 3'b001;
   localparam logic [1:0] JST      = 2'b10;

   exp_t       sb[$];
   int         tests = 0, fails = 0, cyc = 0, gap = 1, ones = 0;
   logic [1:0] lvl = 2'b10;
   bit         stuff_en = 1'b1, errd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [2:0] f;
      exp_t       e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         chk("missed_event_cyc", 32'(cyc), 32'(sb[0].cyc));
         sb.delete(0);
      end
      f = {rx_if.rx_valid, rx_if.rx_eop, rx_if.rx_error};
      if (f[2] === 1'b1 || f[1] === 1'b1 || f[0] === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_strobe", 32'(f), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("strobe_flags", 32'(f), 32'(e.flags));
            chk("strobe_cyc", 32'(cyc), 32'(e.cyc));
            if (e.flags[2]) chk("rx_data", 32'(rx_if.rx_data), 32'(e.data));
         end
      end
   endtask

   task automatic tx_sym(input logic [1:0] ls, input logic [2:0] ev, input logic [7:0] d);
      exp_t e;
      strobe = 1'b1;
      {dp, dn} = ls;
      if (ev != EV_NONE) begin
         e.flags = ev; e.data = d; e.cyc = cyc + 1;
         sb.push_back(e);
      end
      tick();
      strobe = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic idle(input int n);
      repeat (n) tx_sym(JST, EV_NONE, 8'h00);
   endtask

   task automatic tx_sync(input int nz);
      for (int i = 0; i < nz; i++) begin
         lvl = ~lvl;
         tx_sym(lvl, EV_NONE, 8'h00);
      end
      tx_sym(lvl, EV_NONE, 8'h00);
      ones = 0;
   endtask

   task automatic tx_bit(input bit b, input bit last, input logic [7:0] d);
      logic [2:0] ev;
      ev = EV_NONE;
      if (!b) lvl = ~lvl;
      if (!errd) begin
         if (b && ones == 6) begin
            ev = EV_ERR;
            errd = 1'b1;
         end else if (last) begin
            ev = EV_VALID;
         end
      end
      tx_sym(lvl, ev, d);
      ones = b ? ones + 1 : 0;
      if (stuff_en && ones == 6) begin
         lvl = ~lvl;
         tx_sym(lvl, EV_NONE, 8'h00);
         ones = 0;
      end
   endtask

   task automatic tx_byte(input logic [7:0] d);
      for (int i = 0; i < 8; i++) tx_bit(d[i], i == 7, d);
   endtask

   task automatic tx_eop(input bit err);
      tx_sym(LS_SE0, EV_NONE, 8'h00);
      tx_sym(LS_SE0, EV_NONE, 8'h00);
      chk("active_in_se0", 32'(rx_if.rx_active), 32'd1);
      lvl = JST;
      tx_sym(JST, err ? (EV_EOP | EV_ERR) : EV_EOP, 8'h00);
      chk("active_after_eop", 32'(rx_if.rx_active), 32'd0);
      errd = 1'b0;
      ones = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_active"}, 32'(rx_if.rx_active), 32'd0);
      chk({tag, "_valid"},  32'(rx_if.rx_valid),  32'd0);
      chk({tag, "_eop"},    32'(rx_if.rx_eop),    32'd0);
      chk({tag, "_error"},  32'(rx_if.rx_error),  32'd0);
      chk({tag, "_data"},   32'(rx_if.rx_data),   32'd0);
   endtask

   initial begin
      tick();
      tick();
      chk_zero("reset");
      rst_n = 1'b1;

      // Reference packet
      idle(3);
      chk("idle_active", 32'(rx_if.rx_active), 32'd0);
      tx_sync(7);
      chk("sync_active", 32'(rx_if.rx_active), 32'd1);
      tx_byte(8'h69);
      tx_byte(8'hA5);
      tx_eop(1'b0);
      chk("data_held", 32'(rx_if.rx_data), 32'hA5);
      chk("sb_basic", 32'(sb.size()), 32'd0);

      // Stuff bit inserted after six ones
      idle(2);
      tx_sync(7);
      tx_byte(8'hFF);
      tx_byte(8'h01);
      tx_eop(1'b0);
      chk("sb_stuff", 32'(sb.size()), 32'd0);

      // Missing stuff bit
      idle(2);
      stuff_en = 1'b0;
      tx_sync(7);
      tx_byte(8'hFF);
      chk("stufferr_active", 32'(rx_if.rx_active), 32'd1);
      tx_byte(8'h01);
      tx_eop(1'b0);
      stuff_en = 1'b1;
      chk("sb_stufferr", 32'(sb.size()), 32'd0);

      // SYNC too short, then SYNC with six zeros
      idle(2);
      tx_sync(4);
      idle(3);
      chk("short_sync_active", 32'(rx_if.rx_active), 32'd0);
      tx_sync(6);
      chk("sync6_active", 32'(rx_if.rx_active), 32'd1);
      tx_byte(8'h3C);
      tx_eop(1'b0);
      chk("sb_sync", 32'(sb.size()), 32'd0);

      // EOP not on a byte boundary
      idle(2);
      tx_sync(7);
      tx_byte(8'h69);
      tx_bit(1'b1, 1'b0, 8'h00);
      tx_bit(1'b0, 1'b0, 8'h00);
      tx_bit(1'b1, 1'b0, 8'h00);
      tx_eop(1'b1);
      chk("sb_misalign", 32'(sb.size()), 32'd0);

      // SE1 mid-byte
      idle(2);
      tx_sync(7);
      tx_bit(1'b1, 1'b0, 8'h00);
      tx_bit(1'b0, 1'b0, 8'h00);
      tx_bit(1'b1, 1'b0, 8'h00);
      tx_bit(1'b1, 1'b0, 8'h00);
      tx_sym(LS_SE1, EV_ERR, 8'h00);
      errd = 1'b1;
      tx_sym(lvl, EV_NONE, 8'h00);
      lvl = ~lvl;
      tx_sym(lvl, EV_NONE, 8'h00);
      chk("se1_active", 32'(rx_if.rx_active), 32'd1);
      tx_eop(1'b0);
      chk("sb_se1", 32'(sb.size()), 32'd0);

      // Reset mid-byte, coincident with a bit strobe
      idle(2);
      tx_sync(7);
      tx_bit(1'b1, 1'b0, 8'h00);
      tx_bit(1'b0, 1'b0, 8'h00);
      tx_bit(1'b0, 1'b0, 8'h00);
      chk("pre_rst_active", 32'(rx_if.rx_active), 32'd1);
      rst_n = 1'b0;
      strobe = 1'b1;
      lvl = ~lvl;
      {dp, dn} = lvl;
      tick();
      strobe = 1'b0;
      chk_zero("midrst");
      rst_n = 1'b1;
      lvl = JST; ones = 0; errd = 1'b0;
      idle(4);
      chk("sb_rst", 32'(sb.size()), 32'd0);

      // Back-to-back packets, strobe every clock
      gap = 0;
      idle(2);
      tx_sync(7);
      tx_byte(8'h69);
      tx_eop(1'b0);
      idle(2);
      tx_sync(7);
      tx_byte(8'hA5);
      tx_eop(1'b0);
      gap = 1;
      idle(2);
      chk("sb_b2b", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
